dbus_ctrl: RTL and testbench

Data-bus controller that sequences CPU load/store requests onto the two data-side resources: the synchronous data RAM and the 8-bit register port of `fifo_if` (the USB CDC MMIO window). It accepts one request at a time over a valid/ready handshake and decodes the address. It then drives the selected resource for exactly one strobe cycle, performs byte-lane steering and sign extension, and returns a single-cycle response. `busy_o` stalls the PC while an access is in flight.

---
 rtl/dbus_ctrl_if.sv | 23 ++
 rtl/dbus_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dbus_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_ctrl_if.sv
// rtl/dbus_ctrl_if.sv - CPU-side load/store request and response bundle for dbus_ctrl
interface dbus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - data-bus controller sequencing loads/stores onto data RAM and fifo_if MMIO
// Optional DBUS_ALIGN_CHECK_EN: fault misaligned, non-byte MMIO and size-3 accesses instead of masking them.
module dbus_ctrl #(
  parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  dbus_ctrl_if.slave        bus,
  output logic              busy_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              fifo_sel_o,
  output logic              fifo_rd_o,
  output logic              fifo_wr_o,
  output logic [1:0]        fifo_addr_o,
  output logic [7:0]        fifo_wdata_o,
  input  logic [7:0]        fifo_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic        mmio_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;

  logic [31:0] ram_off;
  logic        ram_hit;
  logic        mmio_hit;
  logic        bad;
  logic        fault;
  logic [1:0]  eff_size;
  logic [1:0]  eff_lo;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_src;
  logic [31:0] ld_sh;
  logic [31:0] ld_data;

  // Subtracting the base wraps addresses below it to huge offsets, so one compare covers both bounds.
  assign ram_off  = bus.req_addr - RAM_BASE;
  assign ram_hit  = (ram_off >> (RAM_AW + 2)) == 32'd0;
  assign mmio_hit = bus.req_addr[31:4] == MMIO_BASE[31:4];
  assign fault    = bad | ~(ram_hit | mmio_hit);
  assign busy_o   = (state != IDLE) | bus.req_valid;

  always_comb begin
    eff_size = bus.req_size;
    eff_lo   = bus.req_addr[1:0];
    bad      = 1'b0;
`ifdef DBUS_ALIGN_CHECK_EN
    bad = (bus.req_size == 2'd3)
        | ((bus.req_size == 2'd1) & bus.req_addr[0])
        | ((bus.req_size == 2'd2) & (bus.req_addr[1:0] != 2'b00))
        | (mmio_hit & (bus.req_size != 2'd0));
`else
    if (mmio_hit)
      eff_size = 2'd0;
    else if (bus.req_size == 2'd3)
      eff_size = 2'd2;
    if (eff_size == 2'd1)
      eff_lo[0] = 1'b0;
    else if (eff_size == 2'd2)
      eff_lo = 2'b00;
`endif
  end

  always_comb begin
    st_mask = 4'b1111;
    st_data = bus.req_wdata;
    case (eff_size)
      2'd0: begin
        st_mask = 4'b0001 << eff_lo;
        st_data = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        st_mask = eff_lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // MMIO data always sits in lane 0; lane_q is forced to 0 for it at accept.
  always_comb begin
    ld_src  = mmio_q ? {24'h0, fifo_rdata_i} : ram_rdata_i;
    ld_sh   = ld_src >> {lane_q, 3'b000};
    ld_data = ld_sh;
    case (size_q)
      2'd0:    ld_data = uns_q ? {24'h0, ld_sh[7:0]}  : {{24{ld_sh[7]}}, ld_sh[7:0]};
      2'd1:    ld_data = uns_q ? {16'h0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      mmio_q        <= 1'b0;
      size_q        <= 2'd0;
      lane_q        <= 2'd0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
      ram_en_o      <= 1'b0;
      ram_we_o      <= 4'h0;
      ram_addr_o    <= '0;
      ram_wdata_o   <= 32'h0;
      fifo_sel_o    <= 1'b0;
      fifo_rd_o     <= 1'b0;
      fifo_wr_o     <= 1'b0;
      fifo_addr_o   <= 2'd0;
      fifo_wdata_o  <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            we_q          <= bus.req_we;
            uns_q         <= bus.req_unsigned;
            mmio_q        <= mmio_hit;
            size_q        <= eff_size;
            lane_q        <= mmio_hit ? 2'd0 : eff_lo;
            if (fault) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'h0;
              state         <= RESP;
            end else if (mmio_hit) begin
              fifo_sel_o    <= 1'b1;
              fifo_rd_o     <= ~bus.req_we;
              fifo_wr_o     <= bus.req_we;
              fifo_addr_o   <= bus.req_addr[3:2];
              fifo_wdata_o  <= bus.req_wdata[7:0];
              state         <= ACC;
            end else begin
              ram_en_o      <= 1'b1;
              ram_we_o      <= bus.req_we ? st_mask : 4'h0;
              ram_addr_o    <= bus.req_addr[RAM_AW+1:2];
              ram_wdata_o   <= bus.req_we ? st_data : 32'h0;
              state         <= ACC;
            end
          end
        end
        ACC: begin
          ram_en_o     <= 1'b0;
          ram_we_o     <= 4'h0;
          ram_addr_o   <= '0;
          ram_wdata_o  <= 32'h0;
          fifo_sel_o   <= 1'b0;
          fifo_rd_o    <= 1'b0;
          fifo_wr_o    <= 1'b0;
          fifo_addr_o  <= 2'd0;
          fifo_wdata_o <= 8'h0;
          if (we_q) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            state         <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= ld_data;
          state         <= RESP;
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= 32'h0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb/tb_dbus_ctrl.sv - directed self-checking bench for dbus_ctrl
module tb_dbus_ctrl;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        busy_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        fifo_sel_o, fifo_rd_o, fifo_wr_o;
  logic [1:0]  fifo_addr_o;
  logic [7:0]  fifo_wdata_o;
  logic [7:0]  fifo_rdata_i = 8'h00;

  logic [31:0] mem [0:1023];
  logic        mem_clr = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat, n_ram, n_fifo;
  logic [3:0]  s_we;
  logic [9:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_frd, s_fwr;
  logic [1:0]  s_faddr;
  logic [7:0]  s_fwdata;
  logic [31:0] r_data;
  logic        r_err, s_busy, post_valid, post_ready, seen;

  dbus_ctrl_if bus ();

  dbus_ctrl dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .bus          (bus),
    .busy_o       (busy_o),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i),
    .fifo_sel_o   (fifo_sel_o),
    .fifo_rd_o    (fifo_rd_o),
    .fifo_wr_o    (fifo_wr_o),
    .fifo_addr_o  (fifo_addr_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_rdata_i (fifo_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous RAM, read-before-write, one-cycle read latency.
  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      ram_rdata_i <= 32'h0;
    end else if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    int cyc;
    @(negedge clk_i);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    #1 s_busy = busy_o;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid = 1'b0;
    bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'hA5A5_A5A5; bus.req_we = ~we;
    cyc = 1; lat = 0; n_ram = 0; n_fifo = 0;
    s_we = 0; s_addr = 0; s_wdata = 0; s_frd = 0; s_fwr = 0; s_faddr = 0; s_fwdata = 0;
    r_data = 32'hx; r_err = 1'bx; post_valid = 1'bx; post_ready = 1'bx;
    while (lat == 0 && cyc <= 6) begin
      if (ram_en_o) begin
        n_ram++; s_we = ram_we_o; s_addr = ram_addr_o; s_wdata = ram_wdata_o;
      end
      if (fifo_sel_o) begin
        n_fifo++; s_frd = fifo_rd_o; s_fwr = fifo_wr_o; s_faddr = fifo_addr_o; s_fwdata = fifo_wdata_o;
      end
      if (bus.rsp_valid) begin
        lat = cyc; r_data = bus.rsp_rdata; r_err = bus.rsp_err;
      end else begin
        @(negedge clk_i);
        cyc++;
      end
    end
    if (lat != 0) begin
      @(negedge clk_i);
      post_valid = bus.rsp_valid;
      post_ready = bus.req_ready;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_outs", {31'h0, bus.req_ready | bus.rsp_valid | ram_en_o | fifo_sel_o | busy_o}, 32'h0);
    mem_clr = 1'b0;
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);

    xact(1'b1, 2'd2, 1'b0, 32'h0001_0008, 32'hDEAD_BEEF);
    check("sw_busy", {31'h0, s_busy}, 32'h1);
    check("sw_lat", lat, 2);
    check("sw_nram", n_ram, 1);
    check("sw_we", {28'h0, s_we}, 32'hF);
    check("sw_addr", {22'h0, s_addr}, 32'd2);
    check("sw_wdata", s_wdata, 32'hDEAD_BEEF);
    check("sw_err", {31'h0, r_err}, 32'h0);
    check("sw_pulse", {31'h0, post_valid}, 32'h0);
    check("sw_ready", {31'h0, post_ready}, 32'h1);

    xact(1'b0, 2'd2, 1'b0, 32'h0001_0008, 32'h0);
    check("lw_lat", lat, 3);
    check("lw_we", {28'h0, s_we}, 32'h0);
    check("lw_data", r_data, 32'hDEAD_BEEF);
    check("lw_err", {31'h0, r_err}, 32'h0);

    xact(1'b1, 2'd0, 1'b0, 32'h0001_0003, 32'h1234_5680);
    check("sb_we", {28'h0, s_we}, 32'h8);
    check("sb_wdata", s_wdata, 32'h8080_8080);
    check("sb_addr", {22'h0, s_addr}, 32'd0);
    xact(1'b0, 2'd0, 1'b0, 32'h0001_0003, 32'h0);
    check("lb_signed", r_data, 32'hFFFF_FF80);
    xact(1'b0, 2'd0, 1'b1, 32'h0001_0003, 32'h0);
    check("lb_unsigned", r_data, 32'h0000_0080);
    xact(1'b0, 2'd1, 1'b0, 32'h0001_0002, 32'h0);
    check("lh_signed", r_data, 32'hFFFF_8000);

    xact(1'b1, 2'd1, 1'b0, 32'h0001_0006, 32'hFFFF_1234);
    check("sh_we", {28'h0, s_we}, 32'hC);
    check("sh_wdata", s_wdata, 32'h1234_1234);
    check("sh_addr", {22'h0, s_addr}, 32'd1);

    xact(1'b1, 2'd2, 1'b0, 32'h0001_0FFC, 32'h0BAD_F00D);
    check("top_lat", lat, 2);
    check("top_addr", {22'h0, s_addr}, 32'h3FF);
    xact(1'b0, 2'd2, 1'b0, 32'h0001_1000, 32'h0);
    check("past_lat", lat, 1);
    check("past_err", {31'h0, r_err}, 32'h1);

    xact(1'b1, 2'd0, 1'b0, 32'h8000_0004, 32'h0000_0041);
    check("ms_lat", lat, 2);
    check("ms_nfifo", n_fifo, 1);
    check("ms_nram", n_ram, 0);
    check("ms_ctl", {30'h0, s_fwr, s_frd}, 32'h2);
    check("ms_addr", {30'h0, s_faddr}, 32'd1);
    check("ms_wdata", {24'h0, s_fwdata}, 32'h41);

    fifo_rdata_i = 8'h7F;
    xact(1'b0, 2'd0, 1'b0, 32'h8000_0000, 32'h0);
    check("ml_lat", lat, 3);
    check("ml_ctl", {30'h0, s_fwr, s_frd}, 32'h1);
    check("ml_data", r_data, 32'h0000_007F);
    fifo_rdata_i = 8'h80;
    xact(1'b0, 2'd0, 1'b0, 32'h8000_000C, 32'h0);
    check("ml_faddr", {30'h0, s_faddr}, 32'd3);
    check("ml_signed", r_data, 32'hFFFF_FF80);

    xact(1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'h0);
    check("um_lat", lat, 1);
    check("um_err", {31'h0, r_err}, 32'h1);
    check("um_data", r_data, 32'h0);
    check("um_strobes", n_ram + n_fifo, 0);
    check("um_ready", {31'h0, post_ready}, 32'h1);

    xact(1'b0, 2'd2, 1'b0, 32'h0001_0002, 32'h0);
`ifdef DBUS_ALIGN_CHECK_EN
    check("mis_lat", lat, 1);
    check("mis_err", {31'h0, r_err}, 32'h1);
    check("mis_nram", n_ram, 0);
`else
    check("mis_lat", lat, 3);
    check("mis_err", {31'h0, r_err}, 32'h0);
    check("mis_addr", {22'h0, s_addr}, 32'd0);
    check("mis_data", r_data, 32'h8000_0000);
`endif

    // Reset in the WAIT cycle of a load.
    @(negedge clk_i);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0001_0008;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    check("mid_outs", {26'h0, bus.req_ready, bus.rsp_valid, bus.rsp_err, ram_en_o, fifo_sel_o, busy_o}, 32'h0);
    check("mid_rdata", bus.rsp_rdata, 32'h0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      seen = seen | bus.rsp_valid;
    end
    check("mid_norsp", {31'h0, seen}, 32'h0);
    check("mid_ready", {31'h0, bus.req_ready}, 32'h1);
    xact(1'b0, 2'd2, 1'b0, 32'h0001_0008, 32'h0);
    check("post_lat", lat, 3);
    check("post_data", r_data, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
